down_timer: RTL and testbench

DOWN_TIMER -- requirements
Module: down_timer

---
 rtl/down_timer.sv | 110 +++++++++++
 tb/tb_down_timer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Falling-edge loadable down-counter with IDLE/RUN/EXPIRED control and a terminal-count pulse.
// Define DOWN_TIMER_AUTO_RELOAD_EN to reload from the last loaded value instead of expiring.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] q_r;
    logic             busy_r;
    logic             done_r;
    logic             tc_r;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_r;
`endif

    // Control FSM, count register and all registered outputs, updated on the falling edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            q_r      <= CNT_ZERO;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            tc_r     <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_r <= CNT_ZERO;
`endif
        end else if (load) begin
            q_r  <= din;
            tc_r <= 1'b0;
            if (din != CNT_ZERO) begin
                state_r  <= RUN;
                busy_r   <= 1'b1;
                done_r   <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                reload_r <= din;
`endif
            end else begin
                state_r <= EXPIRED;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    tc_r <= 1'b0;
                end
                RUN: begin
                    if (!en) begin
                        tc_r <= 1'b0;
                    end else if (q_r > CNT_ONE) begin
                        q_r  <= q_r - CNT_ONE;
                        tc_r <= 1'b0;
                    end else if (q_r == CNT_ONE) begin
                        tc_r <= 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                        q_r  <= reload_r;
`else
                        q_r     <= CNT_ZERO;
                        state_r <= EXPIRED;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
`endif
                    end else begin
                        // A zero count in RUN is unreachable; retire it quietly rather than wrap.
                        tc_r    <= 1'b0;
                        q_r     <= CNT_ZERO;
                        state_r <= EXPIRED;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                EXPIRED: begin
                    tc_r <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    q_r     <= CNT_ZERO;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    tc_r    <= 1'b0;
                end
            endcase
        end
    end

    assign q    = q_r;
    assign busy = busy_r;
    assign done = done_r;
    assign tc   = tc_r;

endmodule

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer (WIDTH=4); covers both settings of
// DOWN_TIMER_AUTO_RELOAD_EN.
module tb_down_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] din;
    logic       en;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       tc;

    int checks = 0;
    int errors = 0;

    down_timer #(.WIDTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .din  (din),
        .en   (en),
        .q    (q),
        .busy (busy),
        .done (done),
        .tc   (tc)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [3:0] eq, input logic eb,
                              input logic ed, input logic et);
        check({tag, ".q"},    {12'd0, q},     {12'd0, eq});
        check({tag, ".busy"}, {15'd0, busy},  {15'd0, eb});
        check({tag, ".done"}, {15'd0, done},  {15'd0, ed});
        check({tag, ".tc"},   {15'd0, tc},    {15'd0, et});
    endtask

    // Advance one active (falling) edge and settle before sampling.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        din   = 4'd0;
        en    = 1'b0;
        #1 reset = 1'b0;
        #1 expect_all("por", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;

        // IDLE ignores en
        en = 1'b1;
        step();
        expect_all("idle_en", 4'd0, 1'b0, 1'b0, 1'b0);

        // Basic count
        load = 1'b1; din = 4'd3; en = 1'b0;
        step();
        expect_all("ld3", 4'd3, 1'b1, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        step();
        expect_all("cnt2", 4'd2, 1'b1, 1'b0, 1'b0);
        step();
        expect_all("cnt1", 4'd1, 1'b1, 1'b0, 1'b0);
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        step();
        expect_all("rel3", 4'd3, 1'b1, 1'b0, 1'b1);
        step();
        expect_all("rel2", 4'd2, 1'b1, 1'b0, 1'b0);
`else
        step();
        expect_all("cnt0", 4'd0, 1'b0, 1'b1, 1'b1);
        step();
        expect_all("exp_hold", 4'd0, 1'b0, 1'b1, 1'b0);
        step();
        expect_all("exp_hold2", 4'd0, 1'b0, 1'b1, 1'b0);
`endif

        // Enable gating 1,0,0,1
        load = 1'b1; din = 4'd4; en = 1'b0;
        step();
        expect_all("ld4", 4'd4, 1'b1, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        step();
        expect_all("gate1", 4'd3, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        step();
        expect_all("gate0a", 4'd3, 1'b1, 1'b0, 1'b0);
        step();
        expect_all("gate0b", 4'd3, 1'b1, 1'b0, 1'b0);
        en = 1'b1;
        step();
        expect_all("gate1b", 4'd2, 1'b1, 1'b0, 1'b0);
        step();
        expect_all("at1", 4'd1, 1'b1, 1'b0, 1'b0);

        // Load wins over the terminal-count edge
        load = 1'b1; din = 4'd9; en = 1'b1;
        step();
        expect_all("prio", 4'd9, 1'b1, 1'b0, 1'b0);

        // Zero load
        din = 4'd0;
        step();
        expect_all("zero_ld", 4'd0, 1'b0, 1'b1, 1'b0);
        load = 1'b0; en = 1'b1;
        step();
        expect_all("zero_hold", 4'd0, 1'b0, 1'b1, 1'b0);

        // Maximum load value
        load = 1'b1; din = 4'd15;
        step();
        expect_all("ld15", 4'd15, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        step();
        expect_all("cnt14", 4'd14, 1'b1, 1'b0, 1'b0);

        // Reset mid-count at q=5
        load = 1'b1; din = 4'd7;
        step();
        load = 1'b0;
        step();
        step();
        check("pre_rst.q", {12'd0, q}, 16'd5);
        reset = 1'b0;
        #2 expect_all("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        expect_all("rst_held", 4'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        expect_all("post_rst", 4'd0, 1'b0, 1'b0, 1'b0);

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        // Auto-reload sequence 2,1,2,1,2
        load = 1'b1; din = 4'd2;
        step();
        expect_all("ar2a", 4'd2, 1'b1, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        step();
        expect_all("ar1a", 4'd1, 1'b1, 1'b0, 1'b0);
        step();
        expect_all("ar2b", 4'd2, 1'b1, 1'b0, 1'b1);
        step();
        expect_all("ar1b", 4'd1, 1'b1, 1'b0, 1'b0);
        step();
        expect_all("ar2c", 4'd2, 1'b1, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
